// File: rtl/gauss_pkg.sv
// gauss_pkg -- shared constants and types for the 3x3 Gaussian filter.
//   K_SIDE / K_MID : 1-D weights; the 2-D kernel [1 2 1; 2 4 2; 1 2 1] is their
//                    outer product, so vertical and horizontal passes share them.
//   ROUND / SHIFT  : normalisation, out = (sum + ROUND) >> SHIFT.
//   LINE_W         : width of the saturating line counter.
//   col_t          : one 3-row input column at the default pixel width
//                    (bottom row in the low byte, matching lane0).
package gauss_pkg;

   localparam int unsigned K_SIDE = 1;
   localparam int unsigned K_MID  = 2;
   localparam int unsigned ROUND  = 8;
   localparam int unsigned SHIFT  = 4;
   localparam int unsigned LINE_W = 12;
   localparam int unsigned PIX_W  = 8;

   typedef struct packed {
      logic [PIX_W-1:0] top;
      logic [PIX_W-1:0] centre;
      logic [PIX_W-1:0] bottom;
   } col_t;

endpackage

// File: rtl/gauss_col_sum.sv
// gauss_col_sum -- registered vertical weighted sum of one window column.
//   in_clk  : clock (rising edge)
//   rst_n   : synchronous active-low reset, clears the sum
//   col     : 3-lane column, lane0 = bottom, lane1 = centre, lane2 = top
//   rep_top : column belongs to the first line of a frame; top row is
//             replaced by the centre row
//   sum     : top + 2*centre + bottom, DATA_WIDTH+2 bits (cannot overflow)
module gauss_col_sum
   import gauss_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
)
(
   input  logic                    in_clk,
   input  logic                    rst_n,
   input  logic [3*DATA_WIDTH-1:0] col,
   input  logic                    rep_top,
   output logic [DATA_WIDTH+1:0]   sum
);

   localparam int unsigned SUM_W = DATA_WIDTH + 2;

   logic [DATA_WIDTH-1:0] bottom;
   logic [DATA_WIDTH-1:0] centre;
   logic [DATA_WIDTH-1:0] top;

   assign bottom = col[DATA_WIDTH-1:0];
   assign centre = col[2*DATA_WIDTH-1:DATA_WIDTH];
   assign top    = rep_top ? centre : col[3*DATA_WIDTH-1:2*DATA_WIDTH];

   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         sum <= '0;
      end else begin
         sum <= SUM_W'(K_SIDE * top + K_MID * centre + K_SIDE * bottom);
      end
   end

endmodule

// File: rtl/gauss_3x3_filter.sv
// gauss_3x3_filter -- streaming 3x3 Gaussian filter over pre-buffered columns.
//   in_clk   : clock (rising edge)
//   rst_n    : synchronous active-low reset
//   in_vs    : frame-start pulse (restarts line numbering)
//   in_de    : column valid, one 3-row column per cycle
//   in_data  : lane0 = bottom row, lane1 = centre row, lane2 = top row
//   out_de   : filtered pixel valid
//   out_data : filtered pixel
//   len_err  : sticky, some line length differed from IMG_WIDTH
//
// Pipeline: window shift -> column sums -> horizontal sum -> round/output,
// so a pixel appears 3 cycles after the cycle that completes its window.
module gauss_3x3_filter
   import gauss_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_WIDTH  = 1024
)
(
   input  logic                    in_clk,
   input  logic                    rst_n,
   input  logic                    in_vs,
   input  logic                    in_de,
   input  logic [3*DATA_WIDTH-1:0] in_data,
   output logic                    out_de,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    len_err
);

   localparam int unsigned SUM_W = DATA_WIDTH + 2;
   localparam int unsigned TOT_W = DATA_WIDTH + 4;
   // one spare bit so an over-long line saturates above IMG_WIDTH
   localparam int unsigned CNT_W = $clog2(IMG_WIDTH + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(IMG_WIDTH);

   logic                    de_ok;
   logic                    de_eff;
   logic                    de_d;
   logic                    first;
   logic                    flush;
   logic [3*DATA_WIDTH-1:0] win_l;
   logic [3*DATA_WIDTH-1:0] win_c;
   logic [3*DATA_WIDTH-1:0] win_r;
   logic                    win_rep;
   logic                    v0;
   logic                    v1;
   logic                    v2;
   logic [SUM_W-1:0]        sum_l;
   logic [SUM_W-1:0]        sum_c;
   logic [SUM_W-1:0]        sum_r;
   logic [TOT_W-1:0]        total;
   logic [CNT_W-1:0]        col_cnt;
   logic [LINE_W-1:0]       line_cnt;

   // A reset in the middle of a line must not turn the rest of that line
   // into a new line: columns are ignored until in_de has been seen low.
   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         de_ok <= 1'b0;
      end else if (!in_de) begin
         de_ok <= 1'b1;
      end
   end

   assign de_eff = in_de & de_ok;
   assign first  = de_eff & ~de_d;
   assign flush  = de_d & ~de_eff;

   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         de_d <= 1'b0;
      end else begin
         de_d <= de_eff;
      end
   end

   // Column borders are resolved while shifting: the first column is loaded
   // into both centre and right so it later becomes its own left neighbour,
   // and on flush the right column is kept so it doubles as the centre.
   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         win_l   <= '0;
         win_c   <= '0;
         win_r   <= '0;
         win_rep <= 1'b0;
      end else if (de_eff) begin
         win_l   <= win_c;
         win_c   <= first ? in_data : win_r;
         win_r   <= in_data;
         win_rep <= (line_cnt == '0);
      end else if (flush) begin
         win_l   <= win_c;
         win_c   <= win_r;
      end
   end

   gauss_col_sum #(.DATA_WIDTH(DATA_WIDTH)) u_sum_l (
      .in_clk  (in_clk),
      .rst_n   (rst_n),
      .col     (win_l),
      .rep_top (win_rep),
      .sum     (sum_l)
   );

   gauss_col_sum #(.DATA_WIDTH(DATA_WIDTH)) u_sum_c (
      .in_clk  (in_clk),
      .rst_n   (rst_n),
      .col     (win_c),
      .rep_top (win_rep),
      .sum     (sum_c)
   );

   gauss_col_sum #(.DATA_WIDTH(DATA_WIDTH)) u_sum_r (
      .in_clk  (in_clk),
      .rst_n   (rst_n),
      .col     (win_r),
      .rep_top (win_rep),
      .sum     (sum_r)
   );

   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         v0       <= 1'b0;
         v1       <= 1'b0;
         v2       <= 1'b0;
         total    <= '0;
         out_de   <= 1'b0;
         out_data <= '0;
      end else begin
         v0     <= (de_eff & de_d) | flush;
         v1     <= v0;
         v2     <= v1;
         total  <= TOT_W'(K_SIDE * sum_l + K_MID * sum_c + K_SIDE * sum_r);
         out_de <= v2;
         if (v2) begin
            // total + ROUND peaks at 16*max + 8, still inside TOT_W bits
            out_data <= DATA_WIDTH'((total + ROUND) >> SHIFT);
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         col_cnt <= '0;
      end else if (flush) begin
         col_cnt <= '0;
      end else if (de_eff && (col_cnt != '1)) begin
         col_cnt <= col_cnt + 1'b1;
      end
   end

   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         len_err <= 1'b0;
      end else if (flush && (col_cnt != CNT_EXP)) begin
         len_err <= 1'b1;
      end
   end

   // A frame start always wins over a flush in the same cycle: the flushed
   // line belongs to the old frame.
   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         line_cnt <= '0;
      end else if (in_vs) begin
         line_cnt <= '0;
      end else if (flush && (line_cnt != '1)) begin
         line_cnt <= line_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_gauss_3x3_filter.sv
module tb_gauss_3x3_filter;
   import gauss_pkg::*;

   localparam int IMG_W = 1024;
   localparam int KERN [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
   localparam int N_VEC = 10;

   logic        in_clk;
   logic        rst_n;
   logic        in_vs;
   logic        in_de;
   logic [23:0] in_data;
   logic        out_de;
   logic [7:0]  out_data;
   logic        len_err;

   gauss_3x3_filter #(.DATA_WIDTH(8), .IMG_WIDTH(IMG_W)) dut (
      .in_clk   (in_clk),
      .rst_n    (rst_n),
      .in_vs    (in_vs),
      .in_de    (in_de),
      .in_data  (in_data),
      .out_de   (out_de),
      .out_data (out_data),
      .len_err  (len_err)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   int cyc = 0;
   always @(posedge in_clk) cyc <= cyc + 1;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   tb_line = 0;
   col_t line_buf [$];
   int   exp_buf  [$];
   int   sb_cyc   [$];
   int   sb_val   [$];

   typedef struct packed {
      col_t       c0;
      col_t       c1;
      col_t       c2;
      logic       line0;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
   } vec_t;

   vec_t vecs [N_VEC];

   function automatic col_t mk(input int t, input int c, input int b);
      col_t r;
      r.top    = 8'(t);
      r.centre = 8'(c);
      r.bottom = 8'(b);
      return r;
   endfunction

   function automatic int pix(input col_t p, input int row, input bit line0);
      case (row)
         0:       return line0 ? int'(p.centre) : int'(p.top);
         1:       return int'(p.centre);
         default: return int'(p.bottom);
      endcase
   endfunction

   // Reference: full 2-D convolution over the line with clamped columns.
   function automatic int ref_pix(input int x, input int n, input bit line0);
      int s;
      int c;
      s = 0;
      for (int r = 0; r < 3; r++) begin
         for (int d = 0; d < 3; d++) begin
            c = x + d - 1;
            if (c < 0) c = 0;
            if (c > n - 1) c = n - 1;
            s += KERN[r][d] * pix(line_buf[c], r, line0);
         end
      end
      return (s + 8) / 16;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // One cycle: wait for the falling edge, then score any output pixel.
   task automatic tick();
      @(negedge in_clk);
      if (out_de === 1'b1) begin
         n_tests++;
         if (sb_val.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pixel: got %0d at cycle %0d, required no output", out_data, cyc);
         end else begin
            if (out_data !== 8'(sb_val[0]) || cyc != sb_cyc[0]) begin
               n_fail++;
               $display("FAIL pixel: got %0d at cycle %0d, required %0d at cycle %0d",
                        out_data, cyc, sb_val[0], sb_cyc[0]);
            end
            void'(sb_val.pop_front());
            void'(sb_cyc.pop_front());
         end
      end
   endtask

   task automatic expect_px(input int v);
      // accepted on the next rising edge (cyc+1), visible 3 edges later
      sb_cyc.push_back(cyc + 4);
      sb_val.push_back(v);
   endtask

   task automatic send_line(input int n, input int blank);
      for (int x = 0; x < n; x++) begin
         tick();
         in_de   = 1'b1;
         in_data = line_buf[x];
         if (x > 0) expect_px(exp_buf[x-1]);
      end
      tick();
      in_de   = 1'b0;
      in_data = 24'($urandom);
      expect_px(exp_buf[n-1]);
      repeat (blank) tick();
      tb_line++;
   endtask

   task automatic rand_line(input int n, input int blank);
      line_buf.delete();
      exp_buf.delete();
      for (int x = 0; x < n; x++)
         line_buf.push_back(mk($urandom_range(255), $urandom_range(255), $urandom_range(255)));
      for (int x = 0; x < n; x++)
         exp_buf.push_back(ref_pix(x, n, tb_line == 0));
      send_line(n, blank);
   endtask

   task automatic do_vs();
      tick();
      in_vs = 1'b1;
      tick();
      in_vs = 1'b0;
      tb_line = 0;
   endtask

   task automatic drain();
      repeat (6) tick();
      chk("pixels_outstanding", sb_val.size(), 0);
   endtask

   initial begin
      vecs[0] = {mk(200,200,200), mk(0,0,0),     mk(0,0,0),    1'b0, 8'd150, 8'd50, 8'd0};
      vecs[1] = {mk(0,0,0),       mk(0,160,0),   mk(0,0,0),    1'b0, 8'd20,  8'd40, 8'd20};
      vecs[2] = {mk(0,0,0),       mk(160,0,0),   mk(0,0,0),    1'b0, 8'd10,  8'd20, 8'd10};
      vecs[3] = {mk(0,0,0),       mk(160,0,0),   mk(0,0,0),    1'b1, 8'd0,   8'd0,  8'd0};
      vecs[4] = {mk(0,0,0),       mk(0,160,0),   mk(0,0,0),    1'b1, 8'd30,  8'd60, 8'd30};
      vecs[5] = {mk(255,255,255), mk(255,255,255), mk(255,255,255), 1'b0, 8'd255, 8'd255, 8'd255};
      vecs[6] = {mk(0,0,0),       mk(0,6,0),     mk(0,0,0),    1'b0, 8'd1,   8'd2,  8'd1};
      vecs[7] = {mk(0,0,0),       mk(7,0,0),     mk(0,0,0),    1'b0, 8'd0,   8'd1,  8'd0};
      vecs[8] = {mk(10,20,30),    mk(40,50,60),  mk(70,80,90), 1'b1, 8'd30,  8'd53, 8'd75};
      vecs[9] = {mk(10,20,30),    mk(40,50,60),  mk(70,80,90), 1'b0, 8'd28,  8'd50, 8'd73};

      rst_n   = 1'b0;
      in_vs   = 1'b0;
      in_de   = 1'b0;
      in_data = '0;
      repeat (3) tick();
      chk("reset_out_de", int'(out_de), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_len_err", int'(len_err), 0);
      rst_n = 1'b1;
      tb_line = 0;
      repeat (2) tick();

      // flat field on line 0
      line_buf.delete();
      exp_buf.delete();
      for (int x = 0; x < IMG_W; x++) begin
         line_buf.push_back(mk(100, 100, 100));
         exp_buf.push_back(100);
      end
      send_line(IMG_W, 0);

      // centre-lane impulse at column 5 on line 1
      line_buf.delete();
      exp_buf.delete();
      for (int x = 0; x < IMG_W; x++) begin
         line_buf.push_back(x == 5 ? mk(0, 160, 0) : mk(0, 0, 0));
         exp_buf.push_back(x == 4 ? 20 : x == 5 ? 40 : x == 6 ? 20 : 0);
      end
      send_line(IMG_W, 2);
      drain();
      chk("len_err_after_full_lines", int'(len_err), 0);

      rand_line(10, 1);
      drain();
      chk("len_err_short_line", int'(len_err), 1);
      rand_line(IMG_W, 2);
      drain();
      chk("len_err_held", int'(len_err), 1);

      line_buf = '{mk(77, 77, 77)};
      exp_buf  = '{77};
      send_line(1, 1);
      drain();

      for (int i = 0; i < N_VEC; i++) begin
         if (vecs[i].line0) do_vs();
         line_buf = '{vecs[i].c0, vecs[i].c1, vecs[i].c2};
         exp_buf  = '{int'(vecs[i].e0), int'(vecs[i].e1), int'(vecs[i].e2)};
         send_line(3, 1);
      end
      drain();

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(3) == 0) do_vs();
         rand_line($urandom_range(40, 1), $urandom_range(3));
      end
      drain();

      // reset in the middle of a line; the line keeps streaming afterwards
      line_buf.delete();
      exp_buf.delete();
      for (int x = 0; x < IMG_W; x++)
         line_buf.push_back(mk($urandom_range(255), $urandom_range(255), $urandom_range(255)));
      for (int x = 0; x < IMG_W; x++)
         exp_buf.push_back(ref_pix(x, IMG_W, tb_line == 0));
      for (int x = 0; x < 500; x++) begin
         tick();
         in_de   = 1'b1;
         in_data = line_buf[x];
         if (x > 0) expect_px(exp_buf[x-1]);
      end
      tick();
      rst_n   = 1'b0;
      in_data = line_buf[500];
      tick();
      chk("midreset_out_de", int'(out_de), 0);
      chk("midreset_out_data", int'(out_data), 0);
      chk("midreset_len_err", int'(len_err), 0);
      sb_cyc.delete();
      sb_val.delete();
      rst_n   = 1'b1;
      in_data = line_buf[501];
      for (int x = 502; x < IMG_W; x++) begin
         tick();
         in_data = line_buf[x];
      end
      tick();
      in_de = 1'b0;
      repeat (4) tick();
      drain();
      tb_line = 0;
      rand_line(16, 1);
      drain();
      chk("len_err_after_midreset", int'(len_err), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
